ex_muldiv_unit: RTL and testbench

//   Iterative 16-bit multiply/divide unit in the EX stage. It initiates the pipeline-wide

---
 rtl/ex_muldiv_unit.sv | 199 +++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit
//   Iterative unsigned 16-bit multiply/divide unit for the EX stage. While an
//   operation is in flight it holds 'stop' high, which freezes the pipeline.
//   When the operation finishes it drops 'stop' for one cycle and presents
//   the registered result and its writeback tag.
//
// Ports
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   start         EX holds a valid mul/div instruction
//   op            00 MULLO, 01 MULHI, 10 DIVU, 11 REMU
//   opA, opB      multiplicand/dividend, multiplier/divisor (unsigned)
//   dest_reg      destination register of the EX instruction
//   abort         squash the in-flight operation
//   stop          stall request to the hazard unit
//   result        selected result, held until the next completion
//   result_valid  one-cycle completion pulse
//   WriteRegX     writeback tag, held until the next completion
//   RegWriteX     write enable (completion pulse and dest_reg != 0)
//   div_by_zero   with result_valid: divide had a zero divisor
module ex_muldiv_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int REG_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] opA,
    input  logic [DATA_WIDTH-1:0] opB,
    input  logic [REG_WIDTH-1:0]  dest_reg,
    input  logic                  abort,
    output logic                  stop,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  result_valid,
    output logic [REG_WIDTH-1:0]  WriteRegX,
    output logic                  RegWriteX,
    output logic                  div_by_zero
);

    localparam int                CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [1:0]              r_op;
    logic [REG_WIDTH-1:0]    r_dest;
    logic [DATA_WIDTH-1:0]   r_hi;
    logic [DATA_WIDTH-1:0]   r_lo;
    logic [DATA_WIDTH-1:0]   r_b;

    logic [DATA_WIDTH-1:0]   r_result;
    logic                    r_valid;
    logic [REG_WIDTH-1:0]    r_wreg;
    logic                    r_regwrite;
    logic                    r_dz;

    logic                    w_accept;
    logic                    w_dz;
    logic                    w_stop;
    logic [DATA_WIDTH:0]     w_sum;
    logic [DATA_WIDTH:0]     w_shift;
    logic [DATA_WIDTH:0]     w_diff;
    logic [DATA_WIDTH-1:0]   w_hi_nxt;
    logic [DATA_WIDTH-1:0]   w_lo_nxt;

    // High half for MULHI/REMU, low half for MULLO/DIVU.
    function automatic logic [DATA_WIDTH-1:0] sel_result(
        input logic                  sel_hi,
        input logic [DATA_WIDTH-1:0] hi,
        input logic [DATA_WIDTH-1:0] lo
    );
        return sel_hi ? hi : lo;
    endfunction

    assign w_accept = start && !abort;
    assign w_dz     = w_accept && op[1] && (opB == '0);

    // Iteration datapath. r_hi/r_lo hold {product high, multiplier} for a
    // multiply and {partial remainder, dividend/quotient} for a divide.
    assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    assign w_shift = {r_hi, r_lo[DATA_WIDTH-1]};
    // The partial remainder is always below the divisor, so bit DATA_WIDTH
    // of the difference is exactly the borrow (shifted value < divisor).
    assign w_diff  = w_shift - {1'b0, r_b};

    always_comb begin
        w_hi_nxt = w_sum[DATA_WIDTH:1];
        w_lo_nxt = {w_sum[0], r_lo[DATA_WIDTH-1:1]};
        if (r_op[1]) begin
            w_hi_nxt = w_diff[DATA_WIDTH] ? w_shift[DATA_WIDTH-1:0] : w_diff[DATA_WIDTH-1:0];
            w_lo_nxt = {r_lo[DATA_WIDTH-2:0], ~w_diff[DATA_WIDTH]};
        end
    end

    // Next state and combinational stall request.
    always_comb begin
        w_state_nxt = r_state;
        w_stop      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_stop = w_accept;
                if (w_accept) begin
                    w_state_nxt = w_dz ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                w_stop = 1'b1;
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // Reset must not let a pending start stall the pipeline.
        if (rst) begin
            w_stop = 1'b0;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_result   <= '0;
            r_valid    <= 1'b0;
            r_wreg     <= '0;
            r_regwrite <= 1'b0;
            r_dz       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_dz       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_dz) begin
                        r_valid    <= 1'b1;
                        r_result   <= op[0] ? opA : '1;
                        r_wreg     <= dest_reg;
                        r_regwrite <= (dest_reg != '0);
                        r_dz       <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (!abort && (r_cnt == CNT_LAST)) begin
                        r_valid    <= 1'b1;
                        r_result   <= sel_result(r_op[0], w_hi_nxt, w_lo_nxt);
                        r_wreg     <= r_dest;
                        r_regwrite <= (r_dest != '0);
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    // Operand/iteration registers; contents only matter after an accept.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE) begin
            if (w_accept) begin
                r_op   <= op;
                r_dest <= dest_reg;
                r_hi   <= '0;
                r_b    <= op[1] ? opB : opA;
                r_lo   <= op[1] ? opA : opB;
            end
        end else if (r_state == S_RUN) begin
            r_hi <= w_hi_nxt;
            r_lo <= w_lo_nxt;
        end
    end

    assign stop         = w_stop;
    assign result       = r_result;
    assign result_valid = r_valid;
    assign WriteRegX    = r_wreg;
    assign RegWriteX    = r_regwrite;
    assign div_by_zero  = r_dz;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit
//   Self-checking bench for ex_muldiv_unit: directed cases with hand-computed
//   values, then randomized operations with random aborts, all shadowed by a
//   deadline-based reference model compared on every falling edge.
module tb_ex_muldiv_unit;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        start    = 1'b0;
    logic [1:0]  op       = 2'd0;
    logic [15:0] opA      = 16'd0;
    logic [15:0] opB      = 16'd0;
    logic [3:0]  dest_reg = 4'd0;
    logic        abort    = 1'b0;
    logic        stop;
    logic [15:0] result;
    logic        result_valid;
    logic [3:0]  WriteRegX;
    logic        RegWriteX;
    logic        div_by_zero;

    int total = 0;
    int bad   = 0;

    ex_muldiv_unit #(.DATA_WIDTH(16), .REG_WIDTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .op           (op),
        .opA          (opA),
        .opB          (opB),
        .dest_reg     (dest_reg),
        .abort        (abort),
        .stop         (stop),
        .result       (result),
        .result_valid (result_valid),
        .WriteRegX    (WriteRegX),
        .RegWriteX    (RegWriteX),
        .div_by_zero  (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_result(input logic [1:0] o, input logic [15:0] a,
                                               input logic [15:0] b);
        logic [31:0] p;
        p = {16'd0, a} * {16'd0, b};
        case (o)
            2'd0:    return p[15:0];
            2'd1:    return p[31:16];
            2'd2:    return (b == 16'd0) ? 16'hFFFF : a / b;
            default: return (b == 16'd0) ? a : a % b;
        endcase
    endfunction

    // Reference model: an accepted operation produces its result at an
    // absolute cycle (accept + 17, or accept + 1 for a zero divisor).
    int          cyc = 0;
    bit          m_active = 1'b0;
    int          m_deadline = 0;
    logic [15:0] m_res = 16'd0;
    logic [3:0]  m_dest = 4'd0;
    bit          m_dz = 1'b0;
    logic [15:0] m_hold_res = 16'd0;
    logic [3:0]  m_hold_wreg = 4'd0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active    = 1'b0;
            m_hold_res  = 16'd0;
            m_hold_wreg = 4'd0;
        end else if (m_active) begin
            if (cyc == m_deadline) begin
                m_active    = 1'b0;
                m_hold_res  = m_res;
                m_hold_wreg = m_dest;
            end else if (abort) begin
                m_active = 1'b0;
            end
        end else if (start && !abort) begin
            m_active   = 1'b1;
            m_dz       = op[1] && (opB == 16'd0);
            m_deadline = cyc + (m_dz ? 1 : 17);
            m_res      = ref_result(op, opA, opB);
            m_dest     = dest_reg;
        end
    end

    always @(negedge clk) begin
        bit          e_valid;
        bit          e_stop;
        logic [15:0] e_res;
        logic [3:0]  e_wreg;
        e_valid = !rst && m_active && (cyc == m_deadline);
        e_stop  = !rst && (m_active ? (cyc < m_deadline) : (start && !abort));
        e_res   = e_valid ? m_res : m_hold_res;
        e_wreg  = e_valid ? m_dest : m_hold_wreg;
        chk("model_stop", 32'(stop), 32'(e_stop));
        chk("model_valid", 32'(result_valid), 32'(e_valid));
        chk("model_result", 32'(result), 32'(e_res));
        chk("model_wreg", 32'(WriteRegX), 32'(e_wreg));
        chk("model_regwrite", 32'(RegWriteX), 32'(e_valid && (m_dest != 4'd0)));
        chk("model_dz", 32'(div_by_zero), 32'(e_valid && m_dz));
    end

    // Issues one operation with start held until its completion cycle, then
    // checks latency, stall count and outputs against literal expectations.
    task automatic run_op(input string name, input logic [1:0] o, input logic [15:0] a,
                          input logic [15:0] b, input logic [3:0] d, input logic [15:0] exp_r,
                          input int exp_lat, input bit exp_dz);
        int          stalls;
        int          lat;
        bit          found;
        logic [15:0] g_res;
        logic [3:0]  g_wreg;
        logic        g_rw;
        logic        g_dz;
        stalls = 0; lat = -1; found = 1'b0;
        g_res = 16'd0; g_wreg = 4'd0; g_rw = 1'b0; g_dz = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; op = o; opA = a; opB = b; dest_reg = d; abort = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (result_valid) begin
                found = 1'b1; lat = k;
                g_res = result; g_wreg = WriteRegX; g_rw = RegWriteX; g_dz = div_by_zero;
                break;
            end
            if (stop) stalls++;
        end
        @(posedge clk); #1;
        start = 1'b0;
        chk({name, "_found"}, 32'(found), 32'd1);
        chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({name, "_stalls"}, 32'(stalls), 32'(exp_lat));
        chk({name, "_result"}, 32'(g_res), 32'(exp_r));
        chk({name, "_wreg"}, 32'(g_wreg), 32'(d));
        chk({name, "_regwrite"}, 32'(g_rw), (d != 4'd0) ? 32'd1 : 32'd0);
        chk({name, "_dz"}, 32'(g_dz), 32'(exp_dz));
        @(negedge clk);
        chk({name, "_no_second_op"}, 32'({stop, result_valid}), 32'd0);
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 3))
            0:       return 16'($urandom);
            1:       return 16'd0;
            2:       return 16'hFFFF;
            default: return 16'($urandom_range(0, 20));
        endcase
    endfunction

    task automatic rand_op();
        logic [1:0]  o;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  d;
        bit          do_ab;
        int          ab_k;
        bit          seen;
        bit          was_ab;
        bit          ended;
        o = 2'($urandom_range(0, 3));
        a = pick();
        b = pick();
        d = 4'($urandom_range(0, 15));
        do_ab = ($urandom_range(0, 4) == 0);
        ab_k = $urandom_range(0, 18);
        ended = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; op = o; opA = a; opB = b; dest_reg = d;
        abort = do_ab && (ab_k == 0);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            seen = result_valid;
            was_ab = abort;
            @(posedge clk); #1;
            if (seen || was_ab) begin
                ended = 1'b1;
                break;
            end
            abort = do_ab && (ab_k == k + 1);
        end
        start = 1'b0; abort = 1'b0;
        chk("rand_op_ended", 32'(ended), 32'd1);
        repeat ($urandom_range(0, 2)) begin
            if ($urandom_range(0, 3) == 0) begin
                start = 1'b1; abort = 1'b1;
            end else begin
                start = 1'b0; abort = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0; abort = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_valid;
        // Reset with start high: stall must stay low, outputs zero.
        start = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("reset_stop", 32'(stop), 32'd0);
            chk("reset_outputs", 32'({result, result_valid, WriteRegX, RegWriteX, div_by_zero}), 32'd0);
        end
        @(posedge clk); #1;
        start = 1'b0;
        #2 rst = 1'b0;

        run_op("mullo_3x5", 2'd0, 16'h0003, 16'h0005, 4'd4, 16'h000F, 17, 1'b0);
        run_op("mullo_ffff", 2'd0, 16'hFFFF, 16'hFFFF, 4'd1, 16'h0001, 17, 1'b0);
        run_op("mulhi_ffff", 2'd1, 16'hFFFF, 16'hFFFF, 4'd2, 16'hFFFE, 17, 1'b0);
        run_op("divu_100_7", 2'd2, 16'h0064, 16'h0007, 4'd5, 16'h000E, 17, 1'b0);
        run_op("remu_100_7", 2'd3, 16'h0064, 16'h0007, 4'd0, 16'h0002, 17, 1'b0);
        run_op("divu_by0", 2'd2, 16'h1234, 16'h0000, 4'd3, 16'hFFFF, 1, 1'b1);
        run_op("remu_by0", 2'd3, 16'h1234, 16'h0000, 4'd7, 16'h1234, 1, 1'b1);
        run_op("mullo_zero", 2'd0, 16'h0000, 16'h1234, 4'd8, 16'h0000, 17, 1'b0);
        run_op("divu_big", 2'd2, 16'hFFFF, 16'h0001, 4'd9, 16'hFFFF, 17, 1'b0);

        // start together with abort in IDLE is ignored.
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1; op = 2'd0; opA = 16'd2; opB = 16'd2; dest_reg = 4'd1;
        @(negedge clk);
        chk("idle_abort_stop", 32'(stop), 32'd0);
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("idle_abort_quiet", 32'({stop, result_valid}), 32'd0);

        // Abort at T+5, restart at T+7.
        @(posedge clk); #1;
        start = 1'b1; op = 2'd0; opA = 16'd7; opB = 16'd9; dest_reg = 4'd2;
        repeat (5) @(posedge clk);
        #1 abort = 1'b1;
        @(negedge clk);
        chk("abort_stop_T5", 32'(stop), 32'd1);
        @(posedge clk); #1;
        abort = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("abort_stop_T6", 32'({stop, result_valid}), 32'd0);
        run_op("after_abort", 2'd2, 16'h0064, 16'h0007, 4'd6, 16'h000E, 17, 1'b0);

        // Asynchronous reset mid-RUN.
        @(posedge clk); #1;
        start = 1'b1; op = 2'd1; opA = 16'h4321; opB = 16'h00FF; dest_reg = 4'd9;
        repeat (8) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_stop", 32'(stop), 32'd0);
        chk("async_rst_outputs", 32'({result, result_valid, WriteRegX, RegWriteX, div_by_zero}), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        #2 rst = 1'b0;
        saw_valid = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (result_valid || stop) saw_valid = 1'b1;
        end
        chk("rst_op_lost", 32'(saw_valid), 32'd0);

        for (int i = 0; i < 80; i++) rand_op();

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
